// File: rtl/if_fetch.sv
// if_fetch: owns the PC, keeps one imem request in flight and feeds inst/pc_addr/inst_valid to ifid.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc_addr,
  output logic        inst_valid
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, hold_inst, hold_inst_n, hold_pc, hold_pc_n;
  logic [31:0] inst_n, pc_addr_n, word, word_pc;
  logic drop, drop_n, inst_valid_n, take, keep, give, freeze;
  assign imem_req = state == REQ;
  assign imem_addr = pc;
  always_comb begin
    take = state == WAIT && imem_rvalid && !drop;
    freeze = stall && !redirect;
    keep = take && freeze;
    give = !redirect && !stall && (take || state == HOLD);
    word = state == HOLD ? hold_inst : imem_rdata;
    word_pc = state == HOLD ? hold_pc : pc;
    state_n = state;
    drop_n = drop;
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        state_n = imem_ready ? WAIT : REQ;
        drop_n = redirect && imem_ready;
      end
      WAIT: begin
        state_n = !imem_rvalid ? WAIT : keep ? HOLD : REQ;
        drop_n = !imem_rvalid && (drop || redirect);
      end
      default: state_n = freeze ? HOLD : REQ;
    endcase
    // Redirect drops bits [1:0] of the target and beats any PC advance this cycle
    pc_n = redirect ? redirect_addr & ~32'd3 : take ? pc + PC_STEP : pc;
    hold_inst_n = keep ? imem_rdata : hold_inst;
    hold_pc_n = keep ? pc : hold_pc;
    inst_n = freeze ? inst : give ? word : NOP_INST;
    pc_addr_n = give ? word_pc : pc_addr;
    inst_valid_n = give || (freeze && inst_valid);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      drop <= 1'b0;
      hold_inst <= '0;
      hold_pc <= '0;
      inst <= NOP_INST;
      pc_addr <= '0;
      inst_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      drop <= drop_n;
      hold_inst <= hold_inst_n;
      hold_pc <= hold_pc_n;
      inst <= inst_n;
      pc_addr <= pc_addr_n;
      inst_valid <= inst_valid_n;
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: random imem latency/stall/redirect; delivered stream checked against program-order model.
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  logic clk = 0, rst = 1;
  logic stall = 0, redirect = 0, imem_ready = 0, imem_rvalid = 0;
  logic [31:0] redirect_addr = 0, imem_rdata = 0;
  logic imem_req, inst_valid;
  logic [31:0] imem_addr, inst, pc_addr;
  logic w_stall = 0, w_redirect = 0, w_ready = 1, w_rvalid = 0;
  logic [31:0] w_raddr = 0, w_rdata = 0;
  logic w_req, w_valid;
  logic [31:0] w_addr, w_inst, w_pcaddr;
  int checks = 0, passed = 0, deliveries = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_pc = 0;
  bit pend = 0, w_pend = 0;
  int lat = 0, w_n = 0, w_nacc = 0;
  logic [31:0] paddr = 0, w_paddr = 0;
  logic [31:0] w_pc[2], w_acc[2];
  logic [31:0] p_inst = 0, p_pc = 0;
  logic p_v = 0;

  always #5 clk = ~clk;

  if_fetch dut (.clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .inst(inst), .pc_addr(pc_addr), .inst_valid(inst_valid));

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (.clk(clk), .rst(rst), .stall(w_stall), .redirect(w_redirect),
    .redirect_addr(w_raddr), .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .inst(w_inst), .pc_addr(w_pcaddr), .inst_valid(w_valid));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic topup();
    while (exp_q.size() < 4) begin
      exp_q.push_back(next_pc);
      next_pc += 32'd4;
    end
  endtask

  task automatic step(input int pst, input int prd);
    @(negedge clk);
    imem_rvalid = 0;
    if (pend) begin
      lat--;
      if (lat == 0) begin
        imem_rvalid = 1;
        imem_rdata = paddr ^ KEY;
        pend = 0;
      end
    end
    if (imem_req) check("single_outstanding", 32'(pend), 0);
    imem_ready = $urandom_range(3) != 0;
    if (imem_req && imem_ready) begin
      pend = 1;
      lat = int'($urandom_range(3, 1));
      paddr = imem_addr;
    end
    w_rvalid = w_pend;
    w_rdata = w_paddr ^ KEY;
    w_pend = 0;
    if (w_req) begin
      w_pend = 1;
      w_paddr = w_addr;
      if (w_nacc < 2) begin
        w_acc[w_nacc] = w_addr;
        w_nacc++;
      end
    end
    stall = int'($urandom_range(99)) < pst;
    redirect = int'($urandom_range(99)) < prd;
    if (redirect) begin
      redirect_addr = $urandom_range(1) != 0 ? $urandom : 32'hFFFF_FFF0 + $urandom_range(15);
      exp_q.delete();
      next_pc = redirect_addr & ~32'd3;
    end
    topup();
  endtask

  always @(posedge clk) begin
    logic s, r, g;
    logic [31:0] e;
    s = stall;
    r = redirect;
    g = rst;
    #1;
    if (g) begin
      if (r) begin
        check("redirect_valid", 32'(inst_valid), 0);
        check("redirect_inst", inst, NOP);
      end else if (s) begin
        check("stall_inst", inst, p_inst);
        check("stall_pc", pc_addr, p_pc);
        check("stall_valid", 32'(inst_valid), 32'(p_v));
      end else if (inst_valid) begin
        if (exp_q.size() == 0) check("unexpected_delivery", pc_addr, 32'hx);
        else begin
          e = exp_q.pop_front();
          check("deliver_pc", pc_addr, e);
          check("deliver_inst", inst, e ^ KEY);
          deliveries++;
        end
      end else begin
        check("bubble_inst", inst, NOP);
        check("bubble_pc_keep", pc_addr, p_pc);
      end
      if (w_valid && w_n < 2) begin
        w_pc[w_n] = w_pcaddr;
        check("wrap_inst", w_inst, w_pcaddr ^ KEY);
        w_n++;
      end
    end
    p_inst = inst;
    p_pc = pc_addr;
    p_v = inst_valid;
  end

  initial begin
    #2 rst = 0;
    #1;
    check("reset_inst", inst, NOP);
    check("reset_pc_addr", pc_addr, 0);
    check("reset_valid", 32'(inst_valid), 0);
    check("reset_req", 32'(imem_req), 0);
    check("reset_addr", imem_addr, 0);
    check("reset_w_addr", w_addr, 32'hFFFF_FFFC);
    repeat (2) @(negedge clk);
    rst = 1;
    next_pc = 0;
    topup();
    repeat (40) step(0, 0);
    repeat (1500) step(30, 3);
    repeat (300) step(70, 5);
    for (int i = 0; i < 50 && !pend; i++) step(20, 0);
    check("wait_reached", 32'(pend), 1);
    @(negedge clk);
    rst = 0;
    imem_rvalid = 0;
    stall = 0;
    redirect = 0;
    pend = 0;
    w_pend = 0;
    w_rvalid = 0;
    #1;
    check("midreset_inst", inst, NOP);
    check("midreset_valid", 32'(inst_valid), 0);
    check("midreset_pc_addr", pc_addr, 0);
    check("midreset_req", 32'(imem_req), 0);
    check("midreset_addr", imem_addr, 0);
    @(negedge clk);
    rst = 1;
    imem_rvalid = 1;
    imem_rdata = 32'hDEAD_BEEF;
    exp_q.delete();
    next_pc = 0;
    topup();
    repeat (400) step(30, 3);
    check("progress", 32'(deliveries > 200), 1);
    check("wrap_first_pc", w_pc[0], 32'hFFFF_FFFC);
    check("wrap_second_pc", w_pc[1], 32'h0000_0000);
    check("wrap_second_req", w_acc[1], 32'h0000_0000);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage: owns the program counter and issues one instruction-memory request at a time.
- Accepts the returned word and drives inst/pc_addr/inst_valid into the ifid pipeline latch.
- Honours a stall from the decode/hazard side and a redirect (branch/jump) from execute.
- A one-entry hold buffer keeps a word that returns while stalled, so no fetch is lost or repeated.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded at reset.
- NOP_INST, 32'h0000_0013: bubble word driven on inst when no valid instruction.
- PC_STEP, 4: sequential PC increment.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- stall  in  1  downstream cannot take a new instruction; outputs must hold
- redirect  in  1  flush and restart fetch at redirect_addr
- redirect_addr  in  32  redirect target; bits [1:0] ignored, treated as 0
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, equals current PC
- imem_ready  in  1  request accepted this cycle when imem_req && imem_ready
- imem_rvalid  in  1  response valid, 1 cycle wide, at least 1 cycle after acceptance
- imem_rdata  in  32  response instruction word
- inst  out  32  instruction to ifid
- pc_addr  out  32  address of inst
- inst_valid  out  1  inst/pc_addr carry a real instruction

Behaviour:
- Reset (rst low, async) sets:
  - pc=RESET_PC, state=IDLE, drop=0, hold buffer empty.
  - imem_req=0, imem_addr=RESET_PC.
  - inst=NOP_INST, pc_addr=0, inst_valid=0.
- All outputs are registered except imem_req/imem_addr, which decode from state/pc.
- At most one request is outstanding.
- States:
  - IDLE: imem_req=0. Goes to REQ on the first clock after reset release.
  - REQ: imem_req=1, imem_addr=pc. Goes to WAIT on imem_ready. imem_rvalid in IDLE/REQ is ignored.
  - WAIT: on imem_rvalid:
    - drop=1: discard the word, clear drop, go to REQ.
    - drop=0 and stall=0: next edge inst<=imem_rdata, pc_addr<=pc, inst_valid<=1, pc<=pc+PC_STEP, go to REQ.
    - drop=0 and stall=1: buffer the word and pc, pc<=pc+PC_STEP, go to HOLD.
  - HOLD: imem_req=0. When stall=0, move the buffer to the outputs (inst_valid<=1) and go to REQ.
- Output update rule:
  - When stall=1, inst/pc_addr/inst_valid keep their values.
  - When stall=0 and no word is delivered that cycle, inst<=NOP_INST and inst_valid<=0; pc_addr keeps its value.
- Redirect has the highest priority and overrides stall:
  - Every state: pc<={redirect_addr[31:2],2'b00}, inst<=NOP_INST, inst_valid<=0 on that edge.
  - REQ accepted the same cycle (imem_ready=1): drop<=1, go to WAIT.
  - REQ not accepted: stay in REQ with the new pc.
  - WAIT without rvalid: drop<=1, stay in WAIT.
  - WAIT with rvalid the same cycle: discard the response, go to REQ.
  - HOLD: empty the buffer, go to REQ.
  - IDLE: go to REQ.
- Redirect and delivery in the same cycle: redirect wins, the word is discarded.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
- Reset asserted mid-operation (any state, including an outstanding request) returns to reset values immediately. A late rvalid after release is ignored because the state is IDLE/REQ.

Test Plan:
- Reset, then imem_ready=1 always and rvalid 1 cycle after acceptance with rdata=pc^32'hA5A5_0000 -> sequential outputs pc_addr 0,4,8,C with matching inst, inst_valid=1 each delivery, NOP/valid=0 bubble between.
- Assert stall 3 cycles while a response for pc=8 returns -> outputs frozen at pc_addr=4. After release, pc_addr=8 with its word, and the next request is addr 0xC (no refetch, no skip).
- Redirect to 0x100 in the same cycle as acceptance of addr 0x10 -> 0x10 response discarded, next imem_addr=0x100, first valid output pc_addr=0x100.
- Redirect to 0x203 while in HOLD with stall=1 -> inst=NOP, inst_valid=0, buffer discarded, next request addr 0x200.
- RESET_PC=32'hFFFF_FFFC -> first output pc_addr=FFFF_FFFC, next request addr 0x0.
- Drop rst low during WAIT, release, then pulse stale rvalid -> ignored. Outputs stay at reset values until the RESET_PC response arrives.
